// File: rtl/aes_byte_stream_io.sv
// Byte-serial load/unload wrapper around a combinational AES-128 encrypt core.
// Optional AES_KEY_RETAIN_EN keeps the loaded key across blocks.
module aes_byte_stream_io #(
  parameter int unsigned CORE_LAT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  input  logic         in_sel,
  output logic [127:0] pt_out,
  output logic [127:0] key_out,
  input  logic [127:0] ct_in,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {StLoad, StWait, StShift} state_e;

  localparam logic [3:0] WaitLast = 4'(CORE_LAT - 1);

  state_e       state_q;
  logic [4:0]   pt_cnt_q;
  logic [4:0]   key_cnt_q;
  logic [3:0]   wait_cnt_q;
  logic [3:0]   out_cnt_q;
  logic [127:0] shift_q;

  assign out_byte = shift_q[127:120];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      pt_out     <= '0;
      key_out    <= '0;
      pt_cnt_q   <= '0;
      key_cnt_q  <= '0;
      wait_cnt_q <= '0;
      out_cnt_q  <= '0;
      shift_q    <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StLoad: begin
          // Exit takes priority, so a byte arriving on the exit cycle is dropped.
          if (pt_cnt_q == 5'd16 && key_cnt_q == 5'd16) begin
            state_q    <= StWait;
            wait_cnt_q <= '0;
            busy       <= 1'b1;
          end else if (in_valid) begin
            if (!in_sel) begin
              if (pt_cnt_q != 5'd16) begin
                pt_out   <= {pt_out[119:0], in_byte};
                pt_cnt_q <= pt_cnt_q + 5'd1;
              end
            end else if (key_cnt_q != 5'd16) begin
              key_out   <= {key_out[119:0], in_byte};
              key_cnt_q <= key_cnt_q + 5'd1;
            end
`ifdef AES_KEY_RETAIN_EN
            else begin
              // A key byte on a retained key starts a fresh key.
              key_out   <= {key_out[119:0], in_byte};
              key_cnt_q <= 5'd1;
            end
`endif
          end
        end
        StWait: begin
          if (wait_cnt_q == WaitLast) begin
            shift_q   <= ct_in;
            out_valid <= 1'b1;
            state_q   <= StShift;
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
        StShift: begin
          if (out_valid && out_ready) begin
            shift_q   <= shift_q << 8;
            out_cnt_q <= out_cnt_q + 4'd1;
            if (out_cnt_q == 4'd15) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              pt_cnt_q  <= '0;
`ifndef AES_KEY_RETAIN_EN
              key_cnt_q <= '0;
`endif
              state_q   <= StLoad;
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule
